// File: rtl/conv_stream_layer.sv
// Streaming NUM_CH-channel KxK valid-mode convolution with shift, activation and saturation.
// Two-stage datapath (window capture, MAC+activation). Optional CONV_BIAS_EN adds a latched per-channel bias.
module conv_stream_layer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KDATA_WIDTH = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMGCOL      = 28,
  parameter int IMGROW      = 28,
  parameter int NUM_CH      = 4,
  parameter int OUT_SHIFT   = 0,
  parameter     ACTIVATION  = "RELU",
  localparam int K          = KERNEL_SIZE,
  localparam int ACC_WIDTH  = DATA_WIDTH + KDATA_WIDTH + $clog2(K * K) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CH*K*K*KDATA_WIDTH-1:0] kernel,
`ifdef CONV_BIAS_EN
  input  logic [NUM_CH*ACC_WIDTH-1:0]       bias,
`endif
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_pixel,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]      conv_out,
  output logic                              layer_done_out
);

  localparam int CW = $clog2(IMGCOL);
  localparam int RW = $clog2(IMGROW);
  localparam bit RELU_EN = (ACTIVATION == "RELU");
  localparam logic signed [ACC_WIDTH-1:0] UMAX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                              state_q, state_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [CW-1:0]                       col_q, col_d;
  logic [NUM_CH*K*K*KDATA_WIDTH-1:0]   kern_q, kern_d;
`ifdef CONV_BIAS_EN
  logic [NUM_CH*ACC_WIDTH-1:0]         bias_q, bias_d;
`endif
  logic [DATA_WIDTH-1:0]               pix_q, pix_d;
  logic [CW-1:0]                       pix_col_q, pix_col_d;
  logic                                pix_evt_q, pix_evt_d;
  logic                                pix_vld_q, pix_vld_d;
  logic [DATA_WIDTH-1:0]               lb_q [K-1][IMGCOL];
  logic [DATA_WIDTH-1:0]               lb_d [K-1][IMGCOL];
  logic [DATA_WIDTH-1:0]               win_q [K][K];
  logic [DATA_WIDTH-1:0]               win_d [K][K];
  logic                                win_vld_q, win_vld_d;
  logic                                out_vld_q, out_vld_d;
  logic [NUM_CH*DATA_WIDTH-1:0]        conv_q, conv_d;

  logic [DATA_WIDTH-1:0]               col_vec [K];
  logic signed [ACC_WIDTH-1:0]         acc [NUM_CH];
  logic signed [ACC_WIDTH-1:0]         shifted [NUM_CH];
  logic [NUM_CH*DATA_WIDTH-1:0]        result;
  logic                                stall, accept, last_pix, pipe_empty;

  assign stall      = out_vld_q && !out_ready;
  assign in_ready   = (state_q == S_RUN) && !stall;
  assign accept     = in_valid && in_ready;
  assign last_pix   = (row_q == RW'(IMGROW - 1)) && (col_q == CW'(IMGCOL - 1));
  assign pipe_empty = !pix_vld_q && !win_vld_q && (!out_vld_q || out_ready);

  assign out_valid      = out_vld_q;
  assign conv_out       = conv_q;
  assign layer_done_out = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN: if (pipe_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kern_d = kern_q;
`ifdef CONV_BIAS_EN
    bias_d = bias_q;
`endif
    row_d  = row_q;
    col_d  = col_q;
    if (state_q == S_IDLE && start) begin
      kern_d = kernel;
`ifdef CONV_BIAS_EN
      bias_d = bias;
`endif
      row_d  = '0;
      col_d  = '0;
    end else if (accept) begin
      if (col_q == CW'(IMGCOL - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Whole pipeline freezes while the output beat is stalled, so no skid storage is needed.
  always_comb begin
    pix_d     = pix_q;
    pix_col_d = pix_col_q;
    pix_evt_d = pix_evt_q;
    pix_vld_d = pix_vld_q;
    lb_d      = lb_q;
    win_d     = win_q;
    win_vld_d = win_vld_q;
    out_vld_d = out_vld_q;
    conv_d    = conv_q;
    for (int r = 0; r < K; r++) col_vec[r] = '0;
    if (!stall) begin
      pix_vld_d = accept;
      if (accept) begin
        pix_d     = in_pixel;
        pix_col_d = col_q;
        pix_evt_d = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
      end
      win_vld_d = pix_vld_q && pix_evt_q;
      if (pix_vld_q) begin
        for (int r = 0; r < K - 1; r++) col_vec[r] = lb_q[r][pix_col_q];
        col_vec[K-1] = pix_q;
        for (int r = 0; r < K - 1; r++) lb_d[r][pix_col_q] = col_vec[r+1];
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
          win_d[r][K-1] = col_vec[r];
        end
      end
      out_vld_d = win_vld_q;
      if (win_vld_q) conv_d = result;
    end
  end

  always_comb begin
    result = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef CONV_BIAS_EN
      acc[ch] = $signed(bias_q[ch*ACC_WIDTH +: ACC_WIDTH]);
`else
      acc[ch] = '0;
`endif
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          acc[ch] = acc[ch] + ACC_WIDTH'($signed({1'b0, win_q[r][c]})) *
                    ACC_WIDTH'($signed(kern_q[((ch*K+r)*K+c)*KDATA_WIDTH +: KDATA_WIDTH]));
        end
      end
      shifted[ch] = acc[ch] >>> OUT_SHIFT;
      if (RELU_EN) begin
        if (shifted[ch][ACC_WIDTH-1])  result[ch*DATA_WIDTH +: DATA_WIDTH] = '0;
        else if (shifted[ch] > UMAX)   result[ch*DATA_WIDTH +: DATA_WIDTH] = '1;
        else                           result[ch*DATA_WIDTH +: DATA_WIDTH] = shifted[ch][DATA_WIDTH-1:0];
      end else begin
        if (shifted[ch] < SMIN)        result[ch*DATA_WIDTH +: DATA_WIDTH] = SMIN[DATA_WIDTH-1:0];
        else if (shifted[ch] > SMAX)   result[ch*DATA_WIDTH +: DATA_WIDTH] = SMAX[DATA_WIDTH-1:0];
        else                           result[ch*DATA_WIDTH +: DATA_WIDTH] = shifted[ch][DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      kern_q    <= '0;
`ifdef CONV_BIAS_EN
      bias_q    <= '0;
`endif
      pix_q     <= '0;
      pix_col_q <= '0;
      pix_evt_q <= 1'b0;
      pix_vld_q <= 1'b0;
      win_q     <= '{default: '0};
      win_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      conv_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      kern_q    <= kern_d;
`ifdef CONV_BIAS_EN
      bias_q    <= bias_d;
`endif
      pix_q     <= pix_d;
      pix_col_q <= pix_col_d;
      pix_evt_q <= pix_evt_d;
      pix_vld_q <= pix_vld_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      out_vld_q <= out_vld_d;
      conv_q    <= conv_d;
    end
  end

  // Line-buffer contents are overwritten before use each frame, so they carry no reset.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Bench for conv_stream_layer: three small K=3 4x4 builds (RELU, NONE, shift 12) driven from a
// vector table, plus a default 28x28 build run with random frames against a direct convolution model.
module tb_conv_stream_layer;
  localparam int SN = 4 * 9 * 8;
  localparam int BN = 4 * 25 * 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            start_s, in_valid_s, out_ready_s;
  logic [7:0]      in_pixel_s;
  logic [SN-1:0]   kernel_s;
  logic            in_ready_a, in_ready_b, in_ready_c;
  logic            out_valid_a, out_valid_b, out_valid_c;
  logic            done_a, done_b, done_c;
  logic [31:0]     conv_a, conv_b, conv_c;

  logic            start_d, in_valid_d, out_ready_d, in_ready_d, out_valid_d, done_d;
  logic [7:0]      in_pixel_d;
  logic [BN-1:0]   kernel_d;
  logic [31:0]     conv_d;
`ifdef CONV_BIAS_EN
  logic [4*21-1:0] bias_s;
  logic [4*22-1:0] bias_d;
`endif

  int total = 0;
  int bad   = 0;
  int img_m [784];
  int kern_m [4][25];

  typedef struct packed {
    logic [7:0]       pix;
    logic [3:0][7:0]  k;
    logic [3:0][20:0] b;
    logic [31:0]      ea, eb, ec;
  } vec_t;
  vec_t vecs [$];

  conv_stream_layer #(.KERNEL_SIZE(3), .IMGCOL(4), .IMGROW(4)) u_a (
    .clk(clk), .rst(rst), .start(start_s), .kernel(kernel_s),
`ifdef CONV_BIAS_EN
    .bias(bias_s),
`endif
    .in_valid(in_valid_s), .in_ready(in_ready_a), .in_pixel(in_pixel_s),
    .out_valid(out_valid_a), .out_ready(out_ready_s), .conv_out(conv_a), .layer_done_out(done_a));

  conv_stream_layer #(.KERNEL_SIZE(3), .IMGCOL(4), .IMGROW(4), .ACTIVATION("NONE")) u_b (
    .clk(clk), .rst(rst), .start(start_s), .kernel(kernel_s),
`ifdef CONV_BIAS_EN
    .bias(bias_s),
`endif
    .in_valid(in_valid_s), .in_ready(in_ready_b), .in_pixel(in_pixel_s),
    .out_valid(out_valid_b), .out_ready(out_ready_s), .conv_out(conv_b), .layer_done_out(done_b));

  conv_stream_layer #(.KERNEL_SIZE(3), .IMGCOL(4), .IMGROW(4), .OUT_SHIFT(12)) u_c (
    .clk(clk), .rst(rst), .start(start_s), .kernel(kernel_s),
`ifdef CONV_BIAS_EN
    .bias(bias_s),
`endif
    .in_valid(in_valid_s), .in_ready(in_ready_c), .in_pixel(in_pixel_s),
    .out_valid(out_valid_c), .out_ready(out_ready_s), .conv_out(conv_c), .layer_done_out(done_c));

  conv_stream_layer u_d (
    .clk(clk), .rst(rst), .start(start_d), .kernel(kernel_d),
`ifdef CONV_BIAS_EN
    .bias(bias_d),
`endif
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_pixel(in_pixel_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .conv_out(conv_d), .layer_done_out(done_d));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int pix, k0, k1, k2, k3, b0, b1,
                              input logic [31:0] ea, eb, ec);
    vec_t v;
    v.pix = 8'(pix);
    v.k[0] = 8'(k0); v.k[1] = 8'(k1); v.k[2] = 8'(k2); v.k[3] = 8'(k3);
    v.b[0] = 21'(b0); v.b[1] = 21'(b1); v.b[2] = '0; v.b[3] = '0;
    v.ea = ea; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  // Direct definition of the default-build output at raster position b (24x24 outputs, RELU, no shift).
  function automatic logic [31:0] model_beat(input int b);
    logic [31:0] r;
    int i, j, s;
    i = b / 24;
    j = b % 24;
    r = '0;
    for (int ch = 0; ch < 4; ch++) begin
      s = 0;
      for (int rr = 0; rr < 5; rr++)
        for (int cc = 0; cc < 5; cc++)
          s += img_m[(i + rr) * 28 + j + cc] * kern_m[ch][rr * 5 + cc];
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      r[ch*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  task automatic run_small(input vec_t v, input int idx);
    int sent, acc_cyc, ov_cyc, beats_a, beats_b, beats_c, dones;
    sent = 0; acc_cyc = -1; ov_cyc = -1; beats_a = 0; beats_b = 0; beats_c = 0; dones = 0;
    for (int ch = 0; ch < 4; ch++)
      for (int e = 0; e < 9; e++) kernel_s[(ch*9+e)*8 +: 8] = v.k[ch];
`ifdef CONV_BIAS_EN
    bias_s = v.b;
`endif
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    in_pixel_s = v.pix;
    out_ready_s = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid_s = (sent < 16);
      #1;
      if (in_valid_s && in_ready_a) begin
        if (sent == 10) acc_cyc = cyc;
        sent++;
      end
      if (out_valid_a) begin
        if (ov_cyc < 0) ov_cyc = cyc;
        check($sformatf("v%0d_relu_beat%0d", idx, beats_a), conv_a, v.ea);
        beats_a++;
      end
      if (out_valid_b) begin
        check($sformatf("v%0d_none_beat%0d", idx, beats_b), conv_b, v.eb);
        beats_b++;
      end
      if (out_valid_c) begin
        check($sformatf("v%0d_shift_beat%0d", idx, beats_c), conv_c, v.ec);
        beats_c++;
      end
      @(posedge clk); #1;
      dones += int'(done_a) + int'(done_b) + int'(done_c);
    end
    in_valid_s = 1'b0;
    // Accept seen in iteration c lands on that edge; +2 edges puts out_valid in iteration c+3.
    check($sformatf("v%0d_latency", idx), ov_cyc - acc_cyc, 3);
    check($sformatf("v%0d_beats", idx), {beats_a[15:0], beats_b[15:0], beats_c[15:0]}, {16'd4, 16'd4, 16'd4});
    check($sformatf("v%0d_done_pulses", idx), dones, 3);
  endtask

  task automatic run_big(input bit rand_rdy, input int abort_at);
    int sent, beats, dones, cyc, stall_left, post;
    bit stall_used, held_v;
    logic [31:0] held;
    sent = 0; beats = 0; dones = 0; cyc = 0; stall_left = 0; post = 0;
    stall_used = 0; held_v = 0; held = '0;
    for (int i = 0; i < 784; i++) img_m[i] = int'($urandom_range(0, 255));
    for (int ch = 0; ch < 4; ch++)
      for (int e = 0; e < 25; e++) begin
        kern_m[ch][e] = int'($urandom_range(0, 255)) - 128;
        kernel_d[(ch*25+e)*8 +: 8] = 8'(kern_m[ch][e]);
      end
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    for (int i = 0; i < BN / 32; i++) kernel_d[i*32 +: 32] = $urandom;
    while (cyc < 8000 && post < 4) begin
      in_valid_d = (sent < 784) && ($urandom_range(0, 3) != 0);
      if (sent < 784) in_pixel_d = 8'(img_m[sent]);
      if (!rand_rdy && beats == 100 && !stall_used) begin
        stall_left = 5;
        stall_used = 1;
      end
      out_ready_d = rand_rdy ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
      #1;
      if (held_v) check($sformatf("stall_hold_beat%0d", beats), {out_valid_d, conv_d}, {1'b1, held});
      held_v = 0;
      if (out_valid_d && !out_ready_d) begin
        check("stall_in_ready", in_ready_d, 0);
        held = conv_d;
        held_v = 1;
      end
      if (out_valid_d && out_ready_d) begin
        check($sformatf("big_beat%0d", beats), conv_d, model_beat(beats));
        beats++;
      end
      if (in_valid_d && in_ready_d) sent++;
      @(posedge clk); #1;
      cyc++;
      if (stall_left > 0) stall_left--;
      if (done_d) dones++;
      if (dones > 0) post++;
      if (abort_at > 0 && sent == abort_at) break;
    end
    in_valid_d = 1'b0;
    out_ready_d = 1'b1;
    if (abort_at > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_outputs", {out_valid_d, in_ready_d, done_d, conv_d}, 0);
      repeat (6) begin
        @(posedge clk); #1;
        if (done_d) dones++;
      end
      check("abort_no_done", dones, 0);
    end else begin
      check("big_terminated", post >= 4, 1);
      check("big_beat_count", beats, 576);
      check("big_done_pulses", dones, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_s = 1'b0; in_valid_s = 1'b1; in_pixel_s = 8'hAA; out_ready_s = 1'b0; kernel_s = '0;
    start_d = 1'b0; in_valid_d = 1'b1; in_pixel_d = 8'h55; out_ready_d = 1'b1; kernel_d = '0;
`ifdef CONV_BIAS_EN
    bias_s = '0;
    bias_d = '0;
`endif
    //              pix  k0    k1    k2   k3   b0  b1  relu          none          shift12
    vecs.push_back(mk(1,   1,    1,    1,   1,   0,  0, 32'h09090909, 32'h09090909, 32'h00000000));
    vecs.push_back(mk(1,   1,   -1,    1,   1,   0,  0, 32'h09090009, 32'h0909F709, 32'h00000000));
    vecs.push_back(mk(255, 127,  127,  127, 127, 0,  0, 32'hFFFFFFFF, 32'h7F7F7F7F, 32'h47474747));
    vecs.push_back(mk(255, -128, -128, -128, -128, 0, 0, 32'h00000000, 32'h80808080, 32'h00000000));
    vecs.push_back(mk(2,   2,    3,   -1,   0,   0,  0, 32'h00003624, 32'h00EE3624, 32'h00000000));
`ifdef CONV_BIAS_EN
    vecs.push_back(mk(1,   1,    1,    1,   1,  -9,  1, 32'h09090A00, 32'h09090A00, 32'h00000000));
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", {in_ready_a, in_ready_b, in_ready_c, in_ready_d}, 0);
      check("rst_out_valid", {out_valid_a, out_valid_b, out_valid_c, out_valid_d}, 0);
      check("rst_conv_out", {conv_a | conv_b, conv_c | conv_d}, 0);
      check("rst_done", {done_a, done_b, done_c, done_d}, 0);
      @(posedge clk); #1;
    end
    in_valid_s = 1'b0;
    in_valid_d = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_small(vecs[i], i);

    run_big(1'b0, 0);
    run_big(1'b0, 100);
    run_big(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_stream_layer.md
Name: conv_stream_layer

Overview:
Streaming, multi-channel successor to conv_layer. It accepts one input-image pixel per cycle in raster order over a valid/ready handshake and buffers K-1 rows in line buffers. It computes NUM_CH valid-mode (stride 1) KxK convolutions in parallel, then applies shift, activation and saturation. Results are emitted as one multi-channel beat per output position, and a frame-done pulse marks the end of the frame. It sits between the pixel source and the pooling/next layer.

Parameters:
DATA_WIDTH, 8, pixel and output width (pixels unsigned)
KDATA_WIDTH, 8, kernel coefficient width (signed two's complement)
KERNEL_SIZE, 5, kernel edge K (>=2)
IMGCOL, 28, image columns (>=K)
IMGROW, 28, image rows (>=K)
NUM_CH, 4, output channels (independent kernels)
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before activation
ACTIVATION, "RELU", "RELU" or "NONE"

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame and latches kernel (and bias, if compiled in); honoured only in IDLE
kernel  in  NUM_CH*K*K*KDATA_WIDTH  coefficient (ch,r,c) at index ((ch*K+r)*K+c)
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid&&in_ready
in_pixel  in  DATA_WIDTH  unsigned pixel, raster order
out_valid  out  1  result beat valid
out_ready  in  1  downstream accept
conv_out  out  NUM_CH*DATA_WIDTH  channel ch in bits [ch*DATA_WIDTH +: DATA_WIDTH]
layer_done_out  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, conv_out=0, layer_done_out=0. Row/col counters, window and pipeline valids are cleared; line-buffer contents are don't-care. Reset mid-frame aborts the frame, and no done pulse is produced.
- FSM: IDLE -(start)-> RUN -(last pixel, row IMGROW-1/col IMGCOL-1, accepted)-> DRAIN -(pipeline empty and last beat accepted)-> DONE -> IDLE. DONE lasts 1 cycle with layer_done_out=1. start outside IDLE is ignored.
- in_ready=1 only in RUN and when the pipeline is not stalled. Stall = out_valid && !out_ready; during a stall the whole pipeline holds.
- Line buffers: K-1 rows x IMGCOL entries plus a KxK window register, shifted only on an accepted pixel. The column counter wraps at IMGCOL-1 and increments the row counter.
- Window-complete event: an accepted pixel with row>=K-1 and col>=K-1. Exactly (IMGROW-K+1)*(IMGCOL-K+1) events per frame (576 by default), emitted in raster order.
- Latency: out_valid rises 2 clk after the accepting edge of the window-completing pixel, unstalled (stage 1: window capture; stage 2: MAC + activation registered). No gaps are inserted with continuous input.
- Arithmetic: pixel is zero-extended, then signed multiply by the coefficient. ACC_WIDTH = DATA_WIDTH+KDATA_WIDTH+clog2(K*K)+1, so there is no accumulator overflow. Next, arithmetic right shift by OUT_SHIFT.
- RELU: value<0 gives 0; value>2^DW-1 gives 2^DW-1.
- NONE: signed saturate to [-2^(DW-1), 2^(DW-1)-1], output as two's complement.
- conv_out holds its value while out_valid && !out_ready.
- A kernel change during a frame has no effect; the latched copy is used.
- in_valid outside RUN is ignored (no data consumed).

Optional Feature:
CONV_BIAS_EN
- Defined: adds input port bias (NUM_CH*ACC_WIDTH, signed, channel ch at [ch*ACC_WIDTH +: ACC_WIDTH]), latched on start. Bias is added to the accumulator before the shift.
- Undefined: the port is absent and the bias term is 0.
- Latency is identical in both cases.

Test Plan:
- K=3, 4x4 image all 1, all kernels all +1, out_ready=1 -> 4 beats, every channel =9, first out_valid exactly 2 clk after pixel (2,2) is accepted, layer_done_out pulses once.
- Same image, ch1 kernel all 8'hFF (-1), RELU -> ch1=0 on all beats; ACTIVATION="NONE" -> ch1=8'hF7 (-9).
- Pixels 255, kernel all 127, K=3, OUT_SHIFT=0 -> 291465 saturates to 255; OUT_SHIFT=12 -> 71.
- Default 28x28 with out_ready held low 5 cycles mid-frame -> in_ready low during the stall, conv_out stable, exactly 576 beats with no loss or duplication, 1 done pulse.
- rst asserted at pixel 100, then a new start -> no done pulse for the aborted frame, all outputs 0, second frame results correct.
- CONV_BIAS_EN, K=3 ones image/kernel, bias -9 on ch0 and +1 on ch1 -> ch0=0, ch1=10.
